// File: rtl/nes_bus_pkg.sv
// +------------------------------------------------------------------+
// | nes_bus_pkg : shared CPU bus regions, register map, DMA states   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package nes_bus_pkg;

    typedef enum logic [2:0] {
        RGN_NONE = 3'd0,
        RGN_WRAM = 3'd1,
        RGN_PPU  = 3'd2,
        RGN_DMA  = 3'd3,
        RGN_PAD0 = 3'd4,
        RGN_PAD1 = 3'd5,
        RGN_PRG  = 3'd6
    } region_e;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_ALIGN = 2'd1,
        DMA_RD    = 2'd2,
        DMA_WR    = 2'd3
    } dma_state_e;

    localparam logic [15:0] C_WRAM_LIMIT  = 16'h1FFF;
    localparam logic [15:0] C_PPU_BASE    = 16'h2000;
    localparam logic [15:0] C_PPU_LIMIT   = 16'h3FFF;
    localparam logic [15:0] C_OAMDMA_ADDR = 16'h4014;
    localparam logic [15:0] C_PAD0_ADDR   = 16'h4016;
    localparam logic [15:0] C_PAD1_ADDR   = 16'h4017;
    localparam logic [15:0] C_PRG_BASE    = 16'h8000;

    function automatic region_e decode_region(input logic [15:0] addr);
        region_e r;
        r = RGN_NONE;
        if (addr <= C_WRAM_LIMIT)                           r = RGN_WRAM;
        else if (addr >= C_PPU_BASE && addr <= C_PPU_LIMIT) r = RGN_PPU;
        else if (addr == C_OAMDMA_ADDR)                     r = RGN_DMA;
        else if (addr == C_PAD0_ADDR)                       r = RGN_PAD0;
        else if (addr == C_PAD1_ADDR)                       r = RGN_PAD1;
        else if (addr >= C_PRG_BASE)                        r = RGN_PRG;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pad_shift_reg.sv
// +------------------------------------------------------------------+
// | pad_shift_reg : 8-bit controller latch, parallel load, shift     |
// | right with 1 fill.                     Rev 1.0                   |
// +------------------------------------------------------------------+
`default_nettype none

module pad_shift_reg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       lsb
);

    logic [7:0] shift_q;
    logic [7:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (load)
            shift_d = din;
        else if (shift)
            shift_d = {1'b1, shift_q[7:1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            shift_q <= 8'hFF;
        else
            shift_q <= shift_d;
    end

    assign lsb = shift_q[0];

endmodule

`default_nettype wire

// File: rtl/cpu_bus_mapper.sv
// +------------------------------------------------------------------+
// | cpu_bus_mapper : CPU address decode, read mux, pads, OAM DMA     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module cpu_bus_mapper
    import nes_bus_pkg::*;
#(
    parameter int WRAM_AW  = 11,
    parameter int NUM_PADS = 2,
    parameter int DMA_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           cpu_addr,
    input  logic                  cpu_we,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_rdy,
    output logic [WRAM_AW-1:0]    wram_addr,
    output logic                  wram_we,
    output logic [7:0]            wram_wdata,
    input  logic [7:0]            wram_rdata,
    output logic                  ppu_reg_cs,
    output logic                  ppu_reg_we,
    output logic [2:0]            ppu_reg_addr,
    input  logic [7:0]            ppu_reg_rdata,
    output logic [14:0]           prg_addr,
    input  logic [7:0]            prg_rdata,
    output logic                  oam_we,
    output logic [7:0]            oam_addr,
    output logic [7:0]            oam_wdata,
    input  logic [8*NUM_PADS-1:0] keystates
);

    localparam logic [7:0] C_LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_e state_q, state_d;
    region_e    rsel_q, rsel_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic       strobe_q, strobe_d;
    logic       pad_bit_q, pad_bit_d;

    region_e     cpu_rgn;
    region_e     src_rgn;
    logic [15:0] src_addr;
    logic        cpu_act;
    logic        dma_rd;
    logic [1:0]  pad_rd;
    logic [1:0]  pad_shift;
    logic [1:0]  pad_lsb;
    logic [7:0]  rdata_mux;

    assign cpu_act  = (state_q == DMA_IDLE);
    assign dma_rd   = (state_q == DMA_RD);
    assign cpu_rgn  = decode_region(cpu_addr);
    assign src_addr = {page_q, idx_q};
    assign src_rgn  = decode_region(src_addr);

    // DMA borrows the memory address buses only while fetching a source byte.
    always_comb begin
        wram_addr = cpu_addr[WRAM_AW-1:0];
        prg_addr  = cpu_addr[14:0];
        if (dma_rd) begin
            wram_addr = src_addr[WRAM_AW-1:0];
            prg_addr  = src_addr[14:0];
        end
    end

    assign wram_we      = cpu_act & cpu_we & (cpu_rgn == RGN_WRAM);
    assign wram_wdata   = cpu_wdata;
    assign ppu_reg_cs   = cpu_act & (cpu_rgn == RGN_PPU);
    assign ppu_reg_we   = ppu_reg_cs & cpu_we;
    assign ppu_reg_addr = cpu_addr[2:0];

    assign pad_rd[0] = cpu_act & ~cpu_we & (cpu_rgn == RGN_PAD0);
    assign pad_rd[1] = cpu_act & ~cpu_we & (cpu_rgn == RGN_PAD1);
    assign pad_shift = pad_rd & {2{~strobe_q}};

    for (genvar gi = 0; gi < 2; gi++) begin : g_pad
        if (gi < NUM_PADS) begin : g_present
            pad_shift_reg u_pad (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (strobe_q),
                .shift   (pad_shift[gi]),
                .din     (keystates[8*gi +: 8]),
                .lsb     (pad_lsb[gi])
            );
        end else begin : g_absent
            assign pad_lsb[gi] = 1'b0;
        end
    end

    always_comb begin
        case (rsel_q)
            RGN_WRAM:           rdata_mux = wram_rdata;
            RGN_PPU:            rdata_mux = ppu_reg_rdata;
            RGN_PRG:            rdata_mux = prg_rdata;
            RGN_PAD0, RGN_PAD1: rdata_mux = {7'b0, pad_bit_q};
            default:            rdata_mux = 8'h00;
        endcase
    end

    assign cpu_rdata = rdata_mux;
    assign cpu_rdy   = cpu_act;
    assign oam_we    = (state_q == DMA_WR);
    assign oam_addr  = idx_q;
    assign oam_wdata = rdata_mux;

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        idx_d     = idx_q;
        strobe_d  = strobe_q;
        rsel_d    = RGN_NONE;
        // The shifter advances on the read edge, so the returned bit is captured then.
        pad_bit_d = (cpu_rgn == RGN_PAD1) ? pad_lsb[1] : pad_lsb[0];
        case (state_q)
            DMA_IDLE: begin
                if (!cpu_we && cpu_rgn != RGN_DMA)
                    rsel_d = cpu_rgn;
                if (cpu_we && cpu_rgn == RGN_PAD0)
                    strobe_d = cpu_wdata[0];
                if (cpu_we && cpu_rgn == RGN_DMA) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'd0;
                    state_d = DMA_ALIGN;
                end
            end
            DMA_ALIGN: state_d = DMA_RD;
            DMA_RD: begin
                state_d = DMA_WR;
                if (src_rgn == RGN_WRAM || src_rgn == RGN_PRG)
                    rsel_d = src_rgn;
            end
            DMA_WR: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == C_LAST_IDX) ? DMA_IDLE : DMA_RD;
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= DMA_IDLE;
            rsel_q    <= RGN_NONE;
            page_q    <= 8'd0;
            idx_q     <= 8'd0;
            strobe_q  <= 1'b0;
            pad_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsel_q    <= rsel_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            strobe_q  <= strobe_d;
            pad_bit_q <= pad_bit_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_mapper.sv
// +------------------------------------------------------------------+
// | tb_cpu_bus_mapper : random + directed bench with bus model       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_cpu_bus_mapper;

    localparam int STALL_LEN = 513;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [15:0] keystates;
    logic [7:0]  ks1 = 8'hFF;

    logic [7:0]  cpu_rdata, wram_wdata, oam_addr, oam_wdata;
    logic        cpu_rdy, wram_we, ppu_reg_cs, ppu_reg_we, oam_we;
    logic [10:0] wram_addr;
    logic [2:0]  ppu_reg_addr;
    logic [14:0] prg_addr;
    logic [7:0]  wram_rdata, ppu_reg_rdata, prg_rdata;

    logic [7:0]  u1_cpu_rdata, u1_wram_wdata, u1_oam_addr, u1_oam_wdata;
    logic        u1_cpu_rdy, u1_wram_we, u1_ppu_reg_cs, u1_ppu_reg_we, u1_oam_we;
    logic [10:0] u1_wram_addr;
    logic [2:0]  u1_ppu_reg_addr;
    logic [14:0] u1_prg_addr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_bus_mapper #(.WRAM_AW(11), .NUM_PADS(2), .DMA_LEN(256)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy), .wram_addr(wram_addr), .wram_we(wram_we),
        .wram_wdata(wram_wdata), .wram_rdata(wram_rdata), .ppu_reg_cs(ppu_reg_cs), .ppu_reg_we(ppu_reg_we),
        .ppu_reg_addr(ppu_reg_addr), .ppu_reg_rdata(ppu_reg_rdata), .prg_addr(prg_addr), .prg_rdata(prg_rdata),
        .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata), .keystates(keystates)
    );

    cpu_bus_mapper #(.WRAM_AW(11), .NUM_PADS(1), .DMA_LEN(256)) u1 (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_rdata(u1_cpu_rdata), .cpu_rdy(u1_cpu_rdy), .wram_addr(u1_wram_addr), .wram_we(u1_wram_we),
        .wram_wdata(u1_wram_wdata), .wram_rdata(8'h00), .ppu_reg_cs(u1_ppu_reg_cs), .ppu_reg_we(u1_ppu_reg_we),
        .ppu_reg_addr(u1_ppu_reg_addr), .ppu_reg_rdata(8'h00), .prg_addr(u1_prg_addr), .prg_rdata(8'h00),
        .oam_we(u1_oam_we), .oam_addr(u1_oam_addr), .oam_wdata(u1_oam_wdata), .keystates(ks1)
    );

    function automatic logic [7:0] prg_fn(input logic [14:0] a);
        return a[7:0] ^ {1'b1, a[14:8]};
    endfunction

    function automatic logic [7:0] ppu_fn(input logic [2:0] a);
        return 8'hC0 | (8'(a) * 8'd5);
    endfunction

    // Bus-side devices: synchronous WRAM, PRG ROM pattern, PPU register pattern.
    logic [7:0] mem [0:2047];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
            mem_ready <= 1'b1;
        end else if (wram_we) begin
            mem[wram_addr] <= wram_wdata;
        end
        wram_rdata    <= mem[wram_addr];
        prg_rdata     <= prg_fn(prg_addr);
        ppu_reg_rdata <= ppu_fn(ppu_reg_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state (owned by the compare process).
    logic [7:0] mw [0:2047];
    logic       mw_ready = 1'b0;
    logic [7:0] sh [0:1];
    logic       strobe_m;
    int         stall;
    logic [7:0] dma_page;
    logic       rd_pend;
    logic [7:0] rd_exp;

    function automatic logic [7:0] src_byte(input logic [7:0] page, input int k);
        logic [15:0] s;
        s = {page, 8'(k)};
        if (s < 16'h2000) return mw[s[10:0]];
        if (s >= 16'h8000) return prg_fn(s[14:0]);
        return 8'h00;
    endfunction

    always @(negedge clk) begin : cmp
        logic [15:0] a;
        int          o;
        logic        is_wram, is_ppu, is_prg;
        if (!mw_ready) begin
            for (int i = 0; i < 2048; i++) mw[i] = 8'h00;
            mw_ready = 1'b1;
        end
        if (!reset_n) begin
            stall = 0; strobe_m = 1'b0; sh[0] = 8'hFF; sh[1] = 8'hFF; rd_pend = 1'b0;
        end else begin
            if (rd_pend) chk("rdata", cpu_rdata, rd_exp);
            rd_pend = 1'b0;
            a = cpu_addr;
            if (stall > 0) begin
                o = STALL_LEN - stall;
                chk("rdy_busy", cpu_rdy, 0);
                chk("wram_we_busy", wram_we, 0);
                chk("ppu_cs_busy", ppu_reg_cs, 0);
                if (o >= 2 && o % 2 == 0) begin
                    chk("oam_we_pulse", oam_we, 1);
                    chk("oam_addr", oam_addr, (o - 2) / 2);
                    chk("oam_wdata", oam_wdata, src_byte(dma_page, (o - 2) / 2));
                end else begin
                    chk("oam_we_gap", oam_we, 0);
                end
                stall--;
                if (strobe_m) begin sh[0] = keystates[7:0]; sh[1] = keystates[15:8]; end
            end else begin
                is_wram = (a < 16'h2000);
                is_ppu  = (a >= 16'h2000 && a < 16'h4000);
                is_prg  = (a >= 16'h8000);
                chk("rdy_idle", cpu_rdy, 1);
                chk("oam_we_idle", oam_we, 0);
                chk("wram_we", wram_we, is_wram && cpu_we);
                chk("ppu_cs", ppu_reg_cs, is_ppu);
                chk("ppu_we", ppu_reg_we, is_ppu && cpu_we);
                if (is_wram) chk("wram_addr", wram_addr, a % 2048);
                if (is_ppu)  chk("ppu_addr", ppu_reg_addr, a % 8);
                if (is_prg)  chk("prg_addr", prg_addr, a % 32768);
                if (!cpu_we) begin
                    rd_pend = 1'b1;
                    if (is_wram)              rd_exp = mw[a % 2048];
                    else if (is_ppu)          rd_exp = ppu_fn(a[2:0]);
                    else if (is_prg)          rd_exp = prg_fn(a[14:0]);
                    else if (a == 16'h4016)   rd_exp = {7'b0, sh[0][0]};
                    else if (a == 16'h4017)   rd_exp = {7'b0, sh[1][0]};
                    else                      rd_exp = 8'h00;
                end
                if (strobe_m) begin
                    sh[0] = keystates[7:0]; sh[1] = keystates[15:8];
                end else if (!cpu_we && a == 16'h4016) begin
                    sh[0] = {1'b1, sh[0][7:1]};
                end else if (!cpu_we && a == 16'h4017) begin
                    sh[1] = {1'b1, sh[1][7:1]};
                end
                if (cpu_we) begin
                    if (is_wram) mw[a % 2048] = cpu_wdata;
                    if (a == 16'h4016) strobe_m = cpu_wdata[0];
                    if (a == 16'h4014) begin stall = STALL_LEN; dma_page = cpu_wdata; end
                end
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_addr = a; cpu_we = w; cpu_wdata = d;
    endtask

    task automatic idle();
        drive(16'h5000, 1'b0, 8'h00);
    endtask

    initial begin
        int          low, pulses, post;
        logic        done, found;
        logic [8:0]  pat;
        logic [15:0] ra;
        logic [7:0]  rd;
        int          r;

        cpu_addr = 16'h5000; cpu_we = 1'b0; cpu_wdata = 8'h00; keystates = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_rdy", cpu_rdy, 1);
        chk("rst_oam_we", oam_we, 0);
        chk("rst_rdata", cpu_rdata, 8'h00);
        @(posedge clk); #2 reset_n = 1'b1;

        // Reset fills the shifters with 1s.
        drive(16'h4016, 1'b0, 8'h00); idle(); @(negedge clk);
        chk("rst_pad_fill", cpu_rdata, 8'h01);

        drive(16'h0800, 1'b1, 8'h55); @(negedge clk);
        chk("wr_wram_we", wram_we, 1); chk("wr_wram_addr", wram_addr, 0);
        drive(16'h1800, 1'b0, 8'h00); @(negedge clk);
        chk("rd_wram_we", wram_we, 0); chk("rd_wram_addr", wram_addr, 0);
        idle(); @(negedge clk);
        chk("mirror_rdata", cpu_rdata, 8'h55);

        drive(16'h3005, 1'b0, 8'h00); @(negedge clk);
        chk("ppu_rd_cs", ppu_reg_cs, 1); chk("ppu_rd_addr", ppu_reg_addr, 5); chk("ppu_rd_we", ppu_reg_we, 0);
        drive(16'h3F00, 1'b1, 8'hAB); @(negedge clk);
        chk("ppu_wr_cs", ppu_reg_cs, 1); chk("ppu_wr_addr", ppu_reg_addr, 0); chk("ppu_wr_we", ppu_reg_we, 1);

        keystates = 16'h0081;
        drive(16'h4016, 1'b1, 8'h01);
        drive(16'h4016, 1'b1, 8'h00);
        pat = 9'b1_1000_0001;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) drive(16'h4016, 1'b0, 8'h00); else idle();
            @(negedge clk);
            if (i > 0) chk("pad_seq", cpu_rdata, {7'b0, pat[i-1]});
        end

        drive(16'h5000, 1'b0, 8'h00);
        drive(16'h4017, 1'b0, 8'h00); @(negedge clk);
        chk("unmapped_rd", cpu_rdata, 8'h00);
        drive(16'h8F80, 1'b1, 8'h77); @(negedge clk);
        chk("pad1_absent", u1_cpu_rdata, 8'h00);
        chk("prg_wr_wram_we", wram_we, 0); chk("prg_wr_ppu_cs", ppu_reg_cs, 0);
        chk("prg_wr_ppu_we", ppu_reg_we, 0); chk("prg_wr_oam_we", oam_we, 0);

        for (int i = 0; i < 256; i++) drive(16'h0200 + 16'(i), 1'b1, 8'(i));
        drive(16'h4014, 1'b1, 8'h02);
        low = 0; pulses = 0; done = 1'b0;
        for (int c = 0; c < 700 && !done; c++) begin
            case (c)
                0: drive(16'h0000, 1'b1, 8'hEE);
                1: drive(16'h4014, 1'b1, 8'h80);
                2: drive(16'h4016, 1'b1, 8'h01);
                3: drive(16'h2000, 1'b1, 8'h11);
                default: idle();
            endcase
            @(negedge clk);
            if (!cpu_rdy) low++;
            if (oam_we) begin
                chk("dma_oam_addr", oam_addr, pulses);
                chk("dma_oam_wdata", oam_wdata, pulses);
                pulses++;
            end
            if (low > 0 && cpu_rdy) done = 1'b1;
        end
        chk("dma_done", done, 1);
        chk("dma_stall", low, STALL_LEN);
        chk("dma_pulses", pulses, 256);
        drive(16'h0000, 1'b0, 8'h00); idle(); @(negedge clk);
        chk("dma_ignored_wr", cpu_rdata, 8'h55);

        for (int n = 0; n < 3000; n++) begin
            r  = $urandom_range(0, 99);
            rd = 8'($urandom);
            if (r < 30)      drive(16'($urandom_range(0, 16'h1FFF)), 1'($urandom_range(0, 1)), rd);
            else if (r < 45) drive(16'($urandom_range(16'h2000, 16'h3FFF)), 1'($urandom_range(0, 1)), rd);
            else if (r < 60) drive(16'h4016 + 16'($urandom_range(0, 1)), 1'b0, rd);
            else if (r < 65) drive(16'h4016, 1'b1, rd);
            else if (r < 80) drive(16'($urandom_range(16'h8000, 16'hFFFF)), 1'($urandom_range(0, 1)), rd);
            else if (r < 94) begin
                ra = 16'($urandom_range(16'h4000, 16'h7FFF));
                if (ra == 16'h4014 || ra == 16'h4016 || ra == 16'h4017) ra = 16'h5000;
                drive(ra, 1'($urandom_range(0, 1)), rd);
            end else if (r < 95) begin
                case ($urandom_range(0, 3))
                    0:       rd = 8'($urandom_range(0, 31));
                    1:       rd = 8'($urandom_range(8'h20, 8'h7F));
                    default: rd = 8'($urandom_range(8'h80, 8'hFF));
                endcase
                drive(16'h4014, 1'b1, rd);
            end else idle();
            if ($urandom_range(0, 19) == 0) keystates = 16'($urandom);
        end

        done = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            idle(); @(negedge clk);
            if (cpu_rdy) done = 1'b1;
        end
        chk("drain_done", done, 1);

        drive(16'h4014, 1'b1, 8'h02);
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            idle(); @(negedge clk);
            if (oam_we && oam_addr == 8'd100) found = 1'b1;
        end
        chk("abort_reached", found, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_rdy", cpu_rdy, 1);
        chk("abort_oam_we", oam_we, 0);
        chk("abort_rdata", cpu_rdata, 8'h00);
        @(posedge clk); @(posedge clk); #2 reset_n = 1'b1;
        post = 0;
        for (int c = 0; c < 20; c++) begin
            idle(); @(negedge clk);
            if (oam_we) post++;
        end
        chk("abort_no_oam", post, 0);
        chk("abort_rdy_after", cpu_rdy, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_bus_mapper.md
CPU_BUS_MAPPER -- requirements
Module: cpu_bus_mapper

Interface
REQ-001 Parameters: WRAM_AW, default 11, WRAM address width (mirror size 2^WRAM_AW); NUM_PADS, default 2, controller ports (1 or 2); DMA_LEN, default 256, OAM DMA byte count.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 cpu_addr  in  16  CPU address; cpu_we  in  1  CPU write strobe; cpu_wdata  in  8  CPU write data.
REQ-006 cpu_rdata  out  8  read data, valid one cycle after address; cpu_rdy  out  1  low stalls CPU (DMA active).
REQ-007 wram_addr  out  WRAM_AW; wram_we  out  1; wram_wdata  out  8; wram_rdata  in  8, synchronous, 1-cycle latency.
REQ-008 ppu_reg_cs  out  1; ppu_reg_we  out  1; ppu_reg_addr  out  3; ppu_reg_rdata  in  8, 1-cycle latency.
REQ-009 prg_addr  out  15; prg_rdata  in  8, 1-cycle latency, read-only.
REQ-010 oam_we  out  1; oam_addr  out  8; oam_wdata  out  8  sprite-RAM write port.
REQ-011 keystates  in  8*NUM_PADS  live button state per pad, bit0 = first button shifted.

Function
REQ-012 Decode: 0x0000-0x1FFF WRAM, wram_addr = addr[WRAM_AW-1:0] (mirrored); 0x2000-0x3FFF PPU, ppu_reg_addr = addr[2:0], ppu_reg_cs = 1; 0x4014 DMA; 0x4016/0x4017 pads; 0x8000-0xFFFF PRG, prg_addr = addr[14:0]; all else unmapped.
REQ-013 Select strobes combinational same cycle as address; wram_we/ppu_reg_we = cpu_we qualified by region; PRG and unmapped writes have no effect.
REQ-014 Read-region select registered each cycle; cpu_rdata muxes the matching rdata one cycle later; unmapped reads return 0x00.
REQ-015 Write to 0x4016: strobe <= wdata[0]; while strobe = 1 every pad shift register reloads keystates each cycle.
REQ-016 Read 0x4016 (pad0) / 0x4017 (pad1): return {7'b0, shift[0]} next cycle; if strobe = 0 shift right filling 1, so read 9+ returns 1; if strobe = 1 no shift; 0x4017 reads 0x00 when NUM_PADS = 1.
REQ-017 DMA FSM states IDLE, ALIGN, RD, WR; write to 0x4014 in IDLE latches page = wdata, idx = 0, goes ALIGN.
REQ-018 ALIGN -> RD (1 cycle); RD drives source address {page, idx} -> WR; WR pulses oam_we, oam_addr = idx, oam_wdata = source rdata, idx++; WR -> RD, or IDLE after idx = DMA_LEN-1.
REQ-019 Stall length exactly 1 + 2*DMA_LEN cycles (513 default); cpu_rdy = 0 in every non-IDLE state.
REQ-020 DMA sources: WRAM and PRG pages read normally; any other page reads 0x00 with no ppu_reg_cs assertion.
REQ-021 While DMA active, CPU address/writes ignored: no wram_we, ppu_reg_cs, strobe or DMA retrigger.
REQ-022 CPU writes to oam_* only through DMA; oam_we = 0 outside WR.

Reset
REQ-023 On reset_n low, asynchronously: FSM IDLE, cpu_rdy = 1, oam_we = 0, idx = 0, page = 0, strobe = 0, shift registers 0xFF, read select unmapped (cpu_rdata = 0x00).
REQ-024 Reset mid-DMA aborts transfer immediately; no further oam_we after deassertion.

Structure
REQ-025 Shared package nes_bus_pkg: region enum, region base/limit constants, PPU/DMA/pad register addresses, DMA state enum.
REQ-026 One sub-module pad_shift_reg (8-bit load/shift, fill 1), instantiated NUM_PADS times via generate.

Verification
REQ-027 Write 0x55 to 0x0800, then read 0x1800 -> wram_we once, wram_addr 0x000 both times, cpu_rdata 0x55 cycle after read.
REQ-028 Read 0x3005, then write 0x3F00 -> ppu_reg_cs 1 both cycles, ppu_reg_addr 5 then 0, ppu_reg_we 0 then 1.
REQ-029 pad0 keystates 0x81; write 0x01 then 0x00 to 0x4016; 9 reads of 0x4016 -> bits 1,0,0,0,0,0,0,1,1.
REQ-030 WRAM 0x0200+i = i; write 0x02 to 0x4014 -> cpu_rdy low 513 cycles, 256 oam_we pulses with oam_addr = oam_wdata = i, then cpu_rdy high.
REQ-031 Assert reset_n low during transfer 100 -> cpu_rdy 1 and oam_we 0 immediately, no further OAM writes after release.
REQ-032 Read 0x5000 and 0x4017 with NUM_PADS = 1 -> 0x00; write 0x8F80 -> no write strobe on any port.
